eu_gen2: RTL
============

// Module: eu_gen2
// PURPOSE
//  Parametrised second-generation execution unit. Sequences operand fetch over the BIU, executes one
//  op in an internal ALU, and writes the result back. Adds a compare mode, result flags, an illegal-mode
//  error and a split (non-tristate) bus. Sits between the instruction decoder and the BIU.
// PARAMETERS
//  W            16  datapath / bus width (>=8)
//  IR_W         32  instruction register width
//  IMM_W        16  immediate field width, ir[IMM_W-1:0], sign-extended to W (IMM_W<=W)
//  OPC_LSB      16  LSB of 3-bit opcode field, opcode = ir[OPC_LSB+:3]
//  TIMEOUT_CYC  16  BIU wait limit (used only with EU_TIMEOUT_EN)
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst_n     in   1      synchronous reset, active-low
//  start     in   1      launch request, sampled only in IDLE
//  mode      in   2      00 arith_imm, 01 arith_reg, 10 compare, 11 illegal
//  ir        in   IR_W   instruction; captured together with mode on accepted start
//  busy      out  1      high in every state except IDLE
//  done      out  1      one-cycle pulse on completion (also on error)
//  err       out  1      one-cycle pulse with done on illegal mode or timeout
//  flags     out  3      {N,C,Z}, updated in EXEC only, held otherwise
//  biu_req   out  1      BIU transaction request
//  biu_sel   out  2      00 read A, 01 read B, 10 write result
//  biu_ack   in   1      BIU completion; read data valid on bus_in in the ack cycle
//  bus_in    in   W      read data from BIU
//  bus_out   out  W      result register
//  bus_oe    out  1      high only in WRITE; bus_out meaningful only while high
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; busy, done, err, biu_req, bus_oe = 0; biu_sel=00; flags=000;
//   bus_out=0; operand regs cleared. Reset mid-operation aborts at once; no done pulse is issued.
//  FSM: IDLE -> (start) FETCH_A -> [mode 01: FETCH_B] -> EXEC -> [mode 00/01: WRITE] -> DONE -> IDLE.
//   IDLE with start and mode=11 -> ERR -> IDLE. ERR drives done=1 and err=1 for one cycle.
//  Handshake: biu_req=1 and biu_sel stable for the whole of FETCH_A/FETCH_B/WRITE. The state advances
//   at the posedge where biu_ack=1; biu_req=0 the following cycle unless the next state also requests.
//   A captures bus_in at ack in FETCH_A; B captures at ack in FETCH_B. Imm mode: B = sext(imm).
//  EXEC: one cycle; result and flags registered. Compare mode forces SUB, updates flags, skips WRITE,
//   and leaves bus_out unchanged.
//  ALU ops: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 PASS B.
//   Results are modulo 2^W. Z = (res==0). N = res[W-1]. C = ADD carry-out; SUB borrow (A<B unsigned);
//   SHL1/SHR1 bit shifted out; 0 for logic ops and PASS.
//  Latency with ack in the first cycle of each request: done pulses 4 cycles after the start edge
//   (imm), 5 (reg), 3 (compare). Each wait cycle adds one.
//  start while busy: ignored and not queued. start in the DONE cycle: ignored.
//  ack outside a request state: ignored.
// CONFIGURATION
//  EU_TIMEOUT_EN defined: a counter clears on entry to each request state. If TIMEOUT_CYC cycles pass
//   without ack, the FSM drops biu_req and goes to ERR (done+err pulse); A, B, bus_out and flags keep
//   their prior values.
//  EU_TIMEOUT_EN undefined: no counter; request states wait indefinitely.
// STRUCTURE
//  Shared package eu_pkg: mode encodings, biu_sel encodings, opcode localparams, state enum typedef.
//  Sub-module eu_alu_p #(W): combinational; takes a, b, op; returns res and cout. Flags derive in eu_gen2.
// TESTING
//  imm ADD: W=16, A=0x1234, imm=0x0011, op 000, ack immediate -> WRITE bus_out=0x1245, flags=000,
//   done 4 cycles after start.
//  reg SUB: A=0x0005, B=0x0007 -> bus_out=0xFFFE, flags N=1 C=1 Z=0; three BIU requests in order 00,01,10.
//  compare: A=0x00AA, imm=0x00AA, mode 10 -> no biu_sel=10 request, Z=1, bus_out unchanged, done at +3.
//  illegal: mode 11 -> done=1, err=1 on the next cycle, no biu_req, back to IDLE; start while busy ignored.
//  reset in WRITE with ack withheld: rst_n low 1 cycle -> next cycle bus_oe=0, biu_req=0, busy=0, no done.
//  timeout (EU_TIMEOUT_EN, TIMEOUT_CYC=16): ack never given in FETCH_A -> err+done after 16 wait
//   cycles, flags unchanged; without the macro, still in FETCH_A after 100 cycles.

Source files
------------

// File: rtl/eu_pkg.sv
// eu_pkg -- shared encodings for the eu_gen2 execution unit.  rev 1.0
`default_nettype none

package eu_pkg;

  localparam logic [1:0] MODE_IMM = 2'b00;
  localparam logic [1:0] MODE_REG = 2'b01;
  localparam logic [1:0] MODE_CMP = 2'b10;
  localparam logic [1:0] MODE_ILL = 2'b11;

  localparam logic [1:0] SEL_A  = 2'b00;
  localparam logic [1:0] SEL_B  = 2'b01;
  localparam logic [1:0] SEL_WR = 2'b10;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SHL1 = 3'b101;
  localparam logic [2:0] OP_SHR1 = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_A = 3'd1,
    S_FETCH_B = 3'd2,
    S_EXEC    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

endpackage

`default_nettype wire

// File: rtl/eu_alu_p.sv
// eu_alu_p -- combinational ALU; cout is carry, borrow or the shifted-out bit.  rev 1.0
`default_nettype none

module eu_alu_p #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] res,
  output logic         cout
);
  import eu_pkg::*;

  logic [W:0] sum;
  logic [W:0] diff;

  // Extra top bit holds carry-out for ADD and borrow (a < b) for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      OP_ADD:  begin res = sum[W-1:0];  cout = sum[W];  end
      OP_SUB:  begin res = diff[W-1:0]; cout = diff[W]; end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL1: begin res = {a[W-2:0], 1'b0}; cout = a[W-1]; end
      OP_SHR1: begin res = {1'b0, a[W-1:1]}; cout = a[0];   end
      default: res = b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/eu_gen2.sv
// eu_gen2 -- execution unit: BIU operand fetch, ALU exec, write-back.  rev 1.0
// Optional BIU wait timeout is enabled by defining EU_TIMEOUT_EN.
`default_nettype none

module eu_gen2 #(
  parameter int W           = 16,
  parameter int IR_W        = 32,
  parameter int IMM_W       = 16,
  parameter int OPC_LSB     = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [IR_W-1:0] ir,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [2:0]      flags,
  output logic            biu_req,
  output logic [1:0]      biu_sel,
  input  logic            biu_ack,
  input  logic [W-1:0]    bus_in,
  output logic [W-1:0]    bus_out,
  output logic            bus_oe
);
  import eu_pkg::*;

  state_t         state, state_next;
  logic [1:0]     mode_q;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   imm_ext;
  logic [2:0]     alu_op;
  logic [W-1:0]   alu_res;
  logic           alu_cout;
  logic           timeout;
  logic           unused_ir;

  assign unused_ir = ^ir;

  always_comb begin
    imm_ext              = {W{ir[IMM_W-1]}};
    imm_ext[IMM_W-1:0]   = ir[IMM_W-1:0];
  end

  assign alu_op = (mode_q == MODE_CMP) ? OP_SUB : op_q;

  eu_alu_p #(.W(W)) u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (alu_op),
    .res  (alu_res),
    .cout (alu_cout)
  );

`ifdef EU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cnt;
  logic          req_state;

  assign req_state = (state == S_FETCH_A) || (state == S_FETCH_B) || (state == S_WRITE);
  assign timeout   = req_state && !biu_ack && (wait_cnt == TW'(TIMEOUT_CYC - 1));

  // Any state change restarts the count, so each request state gets a fresh budget.
  always_ff @(posedge clk) begin
    if (!rst_n || (state != state_next)) wait_cnt <= '0;
    else if (req_state)                  wait_cnt <= wait_cnt + TW'(1);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    biu_req    = 1'b0;
    biu_sel    = SEL_A;
    bus_oe     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (mode == MODE_ILL) ? S_ERR : S_FETCH_A;
      end
      S_FETCH_A: begin
        biu_req = 1'b1;
        biu_sel = SEL_A;
        if (biu_ack)      state_next = (mode_q == MODE_REG) ? S_FETCH_B : S_EXEC;
        else if (timeout) state_next = S_ERR;
      end
      S_FETCH_B: begin
        biu_req = 1'b1;
        biu_sel = SEL_B;
        if (biu_ack)      state_next = S_EXEC;
        else if (timeout) state_next = S_ERR;
      end
      S_EXEC: state_next = (mode_q == MODE_CMP) ? S_DONE : S_WRITE;
      S_WRITE: begin
        biu_req = 1'b1;
        biu_sel = SEL_WR;
        bus_oe  = 1'b1;
        if (biu_ack)      state_next = S_DONE;
        else if (timeout) state_next = S_ERR;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Imm and compare modes take B from the immediate at launch; reg mode overwrites it in FETCH_B.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q  <= MODE_IMM;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      flags   <= 3'b000;
      bus_out <= '0;
    end else begin
      if ((state == S_IDLE) && start && (mode != MODE_ILL)) begin
        mode_q <= mode;
        op_q   <= ir[OPC_LSB +: 3];
        b_q    <= imm_ext;
      end
      if ((state == S_FETCH_A) && biu_ack) a_q <= bus_in;
      if ((state == S_FETCH_B) && biu_ack) b_q <= bus_in;
      if (state == S_EXEC) begin
        flags <= {alu_res[W-1], alu_cout, (alu_res == '0)};
        if (mode_q != MODE_CMP) bus_out <= alu_res;
      end
    end
  end

endmodule

`default_nettype wire
